// File: rtl/spi_slave_rx.sv
// spi_slave_rx: receiving end of the 12-bit serial link (LSB first, mosi sampled on sclk fall).
// Latency: done/dout appear SYNC_STAGES+2 clk edges after the first edge sampling the last sclk low.
// Backpressure: none; the master is never stalled, each completed word overwrites dout.
//
// Ports:
//   clk        system clock, everything on posedge
//   rst        synchronous active-high reset
//   sclk       serial clock from master (async, period >= 4 clk)
//   cs         chip select, active low (async)
//   mosi       serial data, LSB first (async)
//   dout       last complete word, held until the next done
//   done       one-cycle pulse, dout valid from that cycle on
//   busy       high from detected cs fall until frame end / abort
//   frame_err  one-cycle pulse when cs rises before DATA_W bits arrived
//   overrun    (only with SPI_RX_OVERRUN_EN) one-cycle pulse per extra sclk fall after a full word
//
// Optional feature macro: SPI_RX_OVERRUN_EN adds the overrun output.

module spi_slave_rx #(
    parameter int DATA_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic [DATA_W-1:0] dout,
    output logic              done,
    output logic              busy,
`ifdef SPI_RX_OVERRUN_EN
    output logic              overrun,
`endif
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECV    = 2'd1,
        WAIT_CS = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers and edge history.
    // cs chain resets to 0 so a cs held low across reset never looks
    // like a fresh falling edge; a high->low transition must be seen.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic sclk_fall;
    logic cs_fall;
    logic cs_rise;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_fall = sclk_prev_q & ~sclk_s;
    assign cs_fall   = cs_prev_q & ~cs_s;
    assign cs_rise   = ~cs_prev_q & cs_s;

    // ------------------------------------------------------------------
    // Frame FSM state
    // ------------------------------------------------------------------
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    // word_rdy_q marks a completed shift register; the word is moved to
    // dout and announced with done one cycle later.
    logic               word_rdy_q, word_rdy_d;
    logic               frame_err_q, frame_err_d;
    logic               busy_q;
    logic [DATA_W-1:0]  dout_q;
    logic               done_q;
`ifdef SPI_RX_OVERRUN_EN
    logic               overrun_q, overrun_d;
`endif

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        word_rdy_d  = 1'b0;
        frame_err_d = 1'b0;
`ifdef SPI_RX_OVERRUN_EN
        overrun_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d   = RECV;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            RECV: begin
                // A fall arriving together with cs rise still carries a
                // valid bit: capture it before judging the frame.
                if (sclk_fall && (!cs_s || cs_rise)) begin
                    shift_d   = shift_q | ({{(DATA_W-1){1'b0}}, mosi_s} << bit_cnt_q);
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        word_rdy_d = 1'b1;
                        state_d    = cs_rise ? IDLE : WAIT_CS;
                    end else if (cs_rise) begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end
                end else if (cs_rise) begin
                    frame_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            WAIT_CS: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end
`ifdef SPI_RX_OVERRUN_EN
                else if (sclk_fall && !cs_s) begin
                    overrun_d = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            word_rdy_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
            dout_q      <= '0;
            done_q      <= 1'b0;
`ifdef SPI_RX_OVERRUN_EN
            overrun_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            word_rdy_q  <= word_rdy_d;
            frame_err_q <= frame_err_d;
            busy_q      <= (state_d != IDLE);
            done_q      <= word_rdy_q;
            // shift_q still holds the finished word here even if a new
            // frame is clearing it on this same edge.
            if (word_rdy_q) begin
                dout_q <= shift_q;
            end
`ifdef SPI_RX_OVERRUN_EN
            overrun_q   <= overrun_d;
`endif
        end
    end

    assign dout      = dout_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
`ifdef SPI_RX_OVERRUN_EN
    assign overrun   = overrun_q;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: drives SPI frames into spi_slave_rx and checks outputs against a frame-level model.
// Latency: expected done cycle = cycle the last sclk fall is driven + SYNC_STAGES + 2.
// Backpressure: n/a (pure stimulus/monitor).
`timescale 1ns/1ps
module tb_spi_slave_rx;

    localparam int W  = 12;
    localparam int SS = 2;
`ifdef SPI_RX_OVERRUN_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         sclk;
    logic         cs;
    logic         mosi;
    logic [W-1:0] dout;
    logic         done;
    logic         busy;
    logic         frame_err;
    logic         overrun;

    spi_slave_rx #(.DATA_W(W), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs        (cs),
        .mosi      (mosi),
        .dout      (dout),
        .done      (done),
        .busy      (busy),
`ifdef SPI_RX_OVERRUN_EN
        .overrun   (overrun),
`endif
        .frame_err (frame_err)
    );

`ifndef SPI_RX_OVERRUN_EN
    assign overrun = 1'b0;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wcyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Frame-level model: scheduled done cycles and the words they carry,
    // plus running totals of frame errors and overruns owed.
    // ------------------------------------------------------------------
    int           due_q[$];
    logic [W-1:0] word_q[$];
    logic [W-1:0] m_dout = '0;
    int           exp_ferr = 0;
    int           exp_ovr  = 0;
    int           n_ferr   = 0;
    int           n_ovr    = 0;
    int           n_done   = 0;
    logic         chk_en   = 1'b0;
    logic         exp_done;
    logic         ferr_prev = 1'b0;
    logic         ovr_prev  = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            m_dout = '0;
            due_q.delete();
            word_q.delete();
        end else if (chk_en) begin
            exp_done = 1'b0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                exp_done = 1'b1;
                void'(due_q.pop_front());
                m_dout = word_q.pop_front();
            end
            chk("done", done, exp_done);
            chk("dout", dout, m_dout);
            chk("done_and_ferr", done & frame_err, 0);
            chk("ferr_width", frame_err & ferr_prev, 0);
            chk("ovr_width", overrun & ovr_prev, 0);
            if (done)      n_done++;
            if (frame_err) n_ferr++;
            if (overrun)   n_ovr++;
        end
        ferr_prev = frame_err;
        ovr_prev  = overrun;
    end

    // One cs-low window with nfalls sclk falls; coinc raises cs on the
    // same instant as the last fall.
    task automatic spi_frame(input logic [W-1:0] w, input int nfalls, input int half,
                             input bit coinc, input int gap);
        logic [31:0] ext;
        ext = $urandom;
        cs = 1'b0;
        wcyc(half + 2);
        chk("busy_hi", busy, 1);
        for (int i = 0; i < nfalls; i++) begin
            sclk = 1'b1;
            mosi = (i < W) ? w[i] : ext[i % 32];
            wcyc(half);
            sclk = 1'b0;
            if (coinc && i == nfalls - 1) cs = 1'b1;
            if (i == W - 1) begin
                due_q.push_back(cyc + SS + 2);
                word_q.push_back(w);
            end
            if (OVR_EN && i >= W && !(coinc && i == nfalls - 1)) exp_ovr++;
            wcyc(half);
        end
        if (!coinc) cs = 1'b1;
        if (nfalls < W) exp_ferr++;
        wcyc(gap);
        if (gap >= 4) chk("busy_lo", busy, 0);
        if (gap >= 6) begin
            chk("ferr_count", n_ferr, exp_ferr);
            chk("ovr_count", n_ovr, exp_ovr);
        end
    endtask

    initial begin
        rst  = 1'b1;
        cs   = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        wcyc(3);
        chk("rst_dout", dout, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_ovr", overrun, 0);
        rst    = 1'b0;
        chk_en = 1'b1;
        wcyc(6);
        chk("idle_no_ferr", n_ferr, 0);

        // 1: single word
        spi_frame(12'hA5C, 12, 2, 1'b0, 8);
        chk("t1_dout", dout, 12'hA5C);
        chk("t1_ndone", n_done, 1);

        // 2: back-to-back
        spi_frame(12'h001, 12, 2, 1'b0, 2);
        spi_frame(12'hFFF, 12, 3, 1'b0, 8);
        chk("t2_dout", dout, 12'hFFF);
        chk("t2_ndone", n_done, 3);

        // 3: abort after 5 falls
        spi_frame(12'h3C3, 5, 2, 1'b0, 8);
        chk("t3_dout", dout, 12'hFFF);
        chk("t3_nferr", n_ferr, 1);
        chk("t3_ndone", n_done, 3);

        // 4: reset mid-frame with cs held low through it
        cs = 1'b0;
        wcyc(4);
        for (int i = 0; i < 6; i++) begin
            sclk = 1'b1; mosi = i[0]; wcyc(2);
            sclk = 1'b0;              wcyc(2);
        end
        rst = 1'b1;
        wcyc(3);
        rst = 1'b0;
        chk("t4_rst_dout", dout, 0);
        wcyc(20);
        chk("t4_busy_idle", busy, 0);
        cs = 1'b1;
        wcyc(8);
        chk("t4_no_ferr", n_ferr, 1);
        spi_frame(12'h5A5, 12, 2, 1'b0, 8);
        chk("t4_dout", dout, 12'h5A5);
        chk("t4_ndone", n_done, 4);

        // 5: last fall coincident with cs rise
        spi_frame(12'h69C, 12, 2, 1'b1, 8);
        chk("t5_dout", dout, 12'h69C);
        chk("t5_ndone", n_done, 5);
        chk("t5_nferr", n_ferr, 1);

        // 6: 13 falls in one window
        spi_frame(12'h123, 13, 3, 1'b0, 8);
        chk("t6_dout", dout, 12'h123);
        chk("t6_ndone", n_done, 6);
        chk("t6_novr", n_ovr, OVR_EN ? 1 : 0);

        // Randomized frames
        for (int k = 0; k < 25; k++) begin
            logic [W-1:0] w;
            int r, nf, hf, gp;
            bit co;
            w  = W'($urandom);
            r  = $urandom_range(0, 9);
            nf = (r < 6) ? 12 : (r < 8) ? $urandom_range(1, 11) : $urandom_range(13, 14);
            hf = $urandom_range(2, 4);
            co = (nf <= 12) && ($urandom_range(0, 3) == 0);
            gp = $urandom_range(2, 8);
            spi_frame(w, nf, hf, co, gp);
        end
        wcyc(10);
        chk("end_ferr_count", n_ferr, exp_ferr);
        chk("end_ovr_count", n_ovr, exp_ovr);
        chk("end_pending", due_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
